// File: rtl/apb_master_arb_pkg.sv
// Shared types and defaults for the two-port APB master arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/apb_master_arb_if.sv
// Requester handshakes plus the shared APB bus.
interface apb_master_arb_if
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req0;
    logic              req1;
    logic              wr0;
    logic              wr1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  req0, req1, wr0, wr1,
        input  addr0, addr1, wdata0, wdata1,
        output done0, done1, err0, err1,
        output rdata0, rdata1,
        output psel, penable, pwrite,
        output paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req0, req1, wr0, wr1,
        output addr0, addr1, wdata0, wdata1,
        input  done0, done1, err0, err1,
        input  rdata0, rdata1,
        input  psel, penable, pwrite,
        input  paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_master_arb_rr_arb2.sv
// Two-way round-robin grant; last points at the most recent winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        unique case (1'b1)
            req == 2'b11: gnt = last ? 2'b01 : 2'b10;
            req == 2'b01: gnt = 2'b01;
            req == 2'b10: gnt = 2'b10;
            default:      gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB slave between two requesters with a watchdog.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    apb_master_arb_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              gsel;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              upd;
    logic              wr_win;
    logic [ADDR_W-1:0] addr_win;
    logic [DATA_W-1:0] wdata_win;
    logic              fin;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    assign req = {bus.req1, bus.req0};
    assign upd = (state == IDLE) && (|req);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .update (upd),
        .gnt    (gnt)
    );

    assign wr_win    = gnt[0] ? bus.wr0    : bus.wr1;
    assign addr_win  = gnt[0] ? bus.addr0  : bus.addr1;
    assign wdata_win = gnt[0] ? bus.wdata0 : bus.wdata1;

    // pready in the watchdog's final cycle still counts as completion
    assign fin      = bus.pready || (cnt == CNT_LAST);
    assign rsp_err  = bus.pready ? bus.pslverr : 1'b1;
    assign rsp_data = (bus.pready && !bus.pwrite) ? bus.prdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            gsel        <= 1'b0;
            bus.psel    <= 1'b0;
            bus.penable <= 1'b0;
            bus.pwrite  <= 1'b0;
            bus.paddr   <= '0;
            bus.pwdata  <= '0;
            bus.done0   <= 1'b0;
            bus.done1   <= 1'b0;
            bus.err0    <= 1'b0;
            bus.err1    <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state      <= SETUP;
                        cnt        <= '0;
                        gsel       <= gnt[1];
                        bus.psel   <= 1'b1;
                        bus.pwrite <= wr_win;
                        bus.paddr  <= addr_win;
                        bus.pwdata <= wdata_win;
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    bus.penable <= 1'b1;
                end
                ACCESS: begin
                    if (!bus.pready) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (fin) begin
                        state       <= DONE;
                        bus.psel    <= 1'b0;
                        bus.penable <= 1'b0;
                        if (gsel) begin
                            bus.done1  <= 1'b1;
                            bus.err1   <= rsp_err;
                            bus.rdata1 <= rsp_data;
                        end else begin
                            bus.done0  <= 1'b1;
                            bus.err0   <= rsp_err;
                            bus.rdata0 <= rsp_data;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench: directed transfers against a configurable APB slave.
module tb_apb_master_arb;
    import apb_arb_pkg::*;

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          acc;
        int          lat;
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apb_master_arb_if bus ();

    apb_master_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    exp_t q[$];

    // slave configuration
    int          s_wait = 1;
    bit          s_hang = 0;
    bit          s_err = 0;
    bit          s_map = 0;
    logic [31:0] s_rdata = '0;
    int          acc_s = 0;

    // monitor state
    int          m_start = 0;
    int          m_acc = 0;
    logic [11:0] m_addr = '0;
    logic        m_wr = 1'b0;
    logic [31:0] m_wdata = '0;
    logic        prev_done = 1'b0;
    logic [31:0] sh_rdata [2];
    logic        sh_err [2];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && bus.psel && bus.penable) begin
            bus.pready = !s_hang && (acc_s == s_wait);
            acc_s++;
        end else begin
            acc_s = 0;
            bus.pready = 1'b0;
        end
        bus.pslverr = s_err && bus.pready;
        bus.prdata = s_map ? (32'hA500_0000 | 32'(bus.paddr)) : s_rdata;
    end

    always @(negedge clk) begin
        exp_t e;
        int   p;
        int   o;
        if (!rst_n) begin
            sh_rdata[0] = '0;
            sh_rdata[1] = '0;
            sh_err[0] = 1'b0;
            sh_err[1] = 1'b0;
            prev_done = 1'b0;
            m_acc = 0;
        end else begin
            if (bus.psel && !bus.penable) begin
                m_start = cyc;
                m_acc = 0;
                m_addr = bus.paddr;
                m_wr = bus.pwrite;
                m_wdata = bus.pwdata;
            end
            if (bus.penable) m_acc++;
            if (bus.done0 || bus.done1) begin
                chk("done_width", 64'(prev_done), 0);
                chk("done_onehot", 64'(bus.done0 && bus.done1), 0);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done want none");
                end else begin
                    e = q.pop_front();
                    p = bus.done1 ? 1 : 0;
                    o = 1 - e.port;
                    chk("grant_port", 64'(p), 64'(e.port));
                    chk("err", 64'(e.port ? bus.err1 : bus.err0), 64'(e.err));
                    chk("rdata", 64'(e.port ? bus.rdata1 : bus.rdata0),
                        64'(e.rdata));
                    chk("access_cycles", 64'(m_acc), 64'(e.acc));
                    chk("latency", 64'(cyc - m_start), 64'(e.lat));
                    chk("paddr", 64'(m_addr), 64'(e.addr));
                    chk("pwrite", 64'(m_wr), 64'(e.wr));
                    chk("pwdata", 64'(m_wdata), 64'(e.wdata));
                    chk("other_rdata", 64'(o ? bus.rdata1 : bus.rdata0),
                        64'(sh_rdata[o]));
                    chk("other_err", 64'(o ? bus.err1 : bus.err0),
                        64'(sh_err[o]));
                    sh_rdata[e.port] = e.rdata;
                    sh_err[e.port] = e.err;
                end
            end
            prev_done = bus.done0 || bus.done1;
        end
    end

    task automatic push(int p, bit wr, logic [11:0] a, logic [31:0] d,
                        bit err, logic [31:0] rd, int acc, int lat);
        exp_t e;
        e.port = p;
        e.err = err;
        e.rdata = rd;
        e.acc = acc;
        e.lat = lat;
        e.addr = a;
        e.wr = wr;
        e.wdata = d;
        q.push_back(e);
    endtask

    task automatic set_req(int p, bit wr, logic [11:0] a, logic [31:0] d);
        if (p == 0) begin
            bus.wr0 = wr;
            bus.addr0 = a;
            bus.wdata0 = d;
            bus.req0 = 1'b1;
        end else begin
            bus.wr1 = wr;
            bus.addr1 = a;
            bus.wdata1 = d;
            bus.req1 = 1'b1;
        end
    endtask

    task automatic wait_done(int p, string nm);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (p == 1 ? bus.done1 : bus.done0) break;
        end
        if (k == 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no done want done within 200 cycles", nm);
        end
        if (p == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
    endtask

    task automatic xfer(int p, bit wr, logic [11:0] a, logic [31:0] d,
                        bit err, logic [31:0] rd, int acc, int lat,
                        string nm);
        push(p, wr, a, d, err, rd, acc, lat);
        set_req(p, wr, a, d);
        wait_done(p, nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.req0 = 0; bus.req1 = 0;
        bus.wr0 = 0; bus.wr1 = 0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;

        repeat (2) @(negedge clk);
        chk("rst_psel", 64'(bus.psel), 0);
        chk("rst_penable", 64'(bus.penable), 0);
        chk("rst_pwrite", 64'(bus.pwrite), 0);
        chk("rst_paddr", 64'(bus.paddr), 0);
        chk("rst_pwdata", 64'(bus.pwdata), 0);
        chk("rst_done", 64'({bus.done0, bus.done1}), 0);
        chk("rst_err", 64'({bus.err0, bus.err1}), 0);
        chk("rst_rdata", 64'({bus.rdata0, bus.rdata1}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        s_wait = 1;
        xfer(0, 1, 12'h004, 32'h0000_00A5, 0, 32'h0, 2, 3, "single_write");

        s_rdata = 32'hDEAD_BEEF;
        xfer(1, 0, 12'h010, 32'h0, 0, 32'hDEAD_BEEF, 2, 3, "single_read");

        s_wait = 0;
        s_rdata = 32'h1234_5678;
        xfer(0, 0, 12'h020, 32'h0, 0, 32'h1234_5678, 1, 2, "zero_wait");

        s_wait = 1;
        s_err = 1;
        xfer(1, 1, 12'h008, 32'h55, 1, 32'h0, 2, 3, "slave_err");
        s_err = 0;

        s_hang = 1;
        xfer(0, 0, 12'h00C, 32'h0, 1, 32'h0, 16, 17, "timeout");
        s_hang = 0;

        s_wait = 15;
        s_rdata = 32'hCAFE_F00D;
        xfer(1, 0, 12'h014, 32'h0, 0, 32'hCAFE_F00D, 16, 17, "late_ready");

        s_hang = 1;
        set_req(0, 0, 12'h030, 32'h0);
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.penable) break;
            end
            chk("reach_access", 64'(bus.penable), 1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_psel", 64'(bus.psel), 0);
        chk("midrst_penable", 64'(bus.penable), 0);
        chk("midrst_done", 64'({bus.done0, bus.done1}), 0);
        bus.req0 = 1'b0;
        s_hang = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_done", 64'({bus.done0, bus.done1}), 0);

        s_wait = 1;
        xfer(0, 1, 12'h018, 32'h0000_0001, 0, 32'h0, 2, 3, "post_reset");

        do_reset();
        s_map = 1;
        for (int r = 0; r < 4; r++) begin
            logic [11:0] a0;
            logic [11:0] a1;
            a0 = 12'h100 + 12'(r * 8);
            a1 = 12'h200 + 12'(r * 8);
            push(0, 0, a0, 32'h0, 0, 32'hA500_0000 | 32'(a0), 2, 3);
            push(1, 0, a1, 32'h0, 0, 32'hA500_0000 | 32'(a1), 2, 3);
            set_req(0, 0, a0, 32'h0);
            set_req(1, 0, a1, 32'h0);
            wait_done(0, "contend_p0");
            wait_done(1, "contend_p1");
        end
        s_map = 0;

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master arbiter that shares a single APB slave port (the timer register block) between a CPU bridge and a secondary requester (debug/DMA). Each requester issues one register read or write via a hold-until-done handshake. The block arbitrates round-robin, sequences the APB SETUP/ACCESS phases, waits on `pready`, and returns read data and an error flag. An access-phase watchdog aborts transfers that never complete.

## Interface
- `ADDR_W`, default 12: APB address width.
- `DATA_W`, default 32: APB data width.
- `TIMEOUT`, default 16: maximum ACCESS cycles with `pready` low before the transfer is aborted; must be ≥ 2.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0`, `req1` in 1: transfer request; held high, with its fields stable, until the matching `done` pulse.
- `wr0`, `wr1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in ADDR_W: register address.
- `wdata0`, `wdata1` in DATA_W: write data.
- `done0`, `done1` out 1: one-cycle completion pulse.
- `err0`, `err1` out 1: valid with `done`; 1 = `pslverr` or timeout.
- `rdata0`, `rdata1` out DATA_W: read data, valid with `done`; held until the next completion for that requester.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_W, `pwdata` out DATA_W: APB address and write data.
- `prdata` in DATA_W, `pready` in 1, `pslverr` in 1: APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - `psel` = 0, `penable` = 0.
  - If any `req` is high: latch the winner's `wr`/`addr`/`wdata` into `pwrite`/`paddr`/`pwdata` and go to SETUP.
- **Arbitration**
  - A single requesting port wins.
  - If both request, the port not granted last wins.
  - The `last` pointer updates on grant.
  - The reset value of `last` is 1, so port 0 wins the first tie.
- **SETUP** (one cycle)
  - `psel` = 1, `penable` = 0.
  - Go to ACCESS.
- **ACCESS**
  - `psel` = 1, `penable` = 1. `paddr`/`pwrite`/`pwdata` stay stable.
  - `pready` = 1: capture `prdata` (or 0 for writes) into `rdataN`. Set `errN` = `pslverr`. Go to DONE.
  - `pready` = 0: increment the wait counter. When the counter reaches `TIMEOUT`:
    - `rdataN` = 0, `errN` = 1.
    - Go to DONE. `psel`/`penable` drop in DONE.
- **DONE** (one cycle)
  - `psel` = 0, `penable` = 0.
  - `doneN` = 1 for the granted port only.
  - All requests are ignored. Go to IDLE.
- **Requester protocol**
  - Drop `req` no later than the cycle after `done` is sampled.
  - If a requester drops `req` mid-transfer, the transfer still completes and `done` still pulses.
- `rdata`/`err` of the non-granted port are unchanged by any transfer.

## Timing
- **Reset values**
  - All outputs are 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `done*`, `err*`, `rdata*`.
  - FSM = IDLE, wait counter = 0, `last` = 1.
- **Reset mid-transfer:** immediate asynchronous return to reset values. No `done` pulse.
- **Latency:** `req` sampled in IDLE at cycle 0, SETUP at cycle 1, first ACCESS at cycle 2.
  - Timer slave (one wait state): `pready` high at cycle 3, `done` at cycle 4.
  - Zero-wait slave: `done` at cycle 3.
- **Throughput:** minimum 4 cycles per transfer (IDLE, SETUP, ACCESS, DONE); 5 with the timer slave.
- **Timeout:** ACCESS lasts exactly `TIMEOUT` cycles, then DONE.
  - If `pready` rises in the same cycle the counter reaches `TIMEOUT`, normal completion wins (`err` = `pslverr`).
- **Simultaneous requests:** `req0` and `req1` both rising in the same cycle are handled per the round-robin rule. The loser waits at most one transfer.
- **Wait counter:** width `$clog2(TIMEOUT+1)`, cleared on entry to SETUP, no wrap.

## Structure
- Package `apb_arb_pkg`:
  - state enum (IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10, DONE = 2'b11);
  - default `ADDR_W`/`DATA_W`/`TIMEOUT` constants.
- One sub-module, `rr_arb2`: 2-way round-robin grant with the `last` pointer. Inputs: `req[1:0]`, `update`. Output: one-hot `gnt[1:0]`.
- The FSM, wait counter and response registers live in the top module.

## Test plan
- **Single write:** `req0`, `wr0` = 1, `addr0` = 0x004, `wdata0` = 0x0000_00A5 against a one-wait-state slave → SETUP at cycle 1, `penable` on cycles 2–3, `done0` at cycle 4, `err0` = 0.
- **Single read:** `req1` read at `addr1` = 0x010 with slave `prdata` = 0xDEAD_BEEF → `rdata1` = 0xDEAD_BEEF with `done1`. `rdata0` unchanged.
- **Contention:** `req0` and `req1` rise in the same cycle after reset → port 0 is served first and port 1 next. Repeated 4 times, grants alternate 0, 1, 0, 1.
- **Slave error:** `pslverr` = 1 with `pready` → `errN` = 1, `done` still one cycle wide.
- **Timeout:** `pready` held at 0 with `TIMEOUT` = 16 → exactly 16 ACCESS cycles, then `done` with `err` = 1 and `rdata` = 0. `pready` rising on the 16th cycle instead gives `err` = 0.
- **Reset mid-ACCESS:** assert `rst_n` low during ACCESS → `psel`/`penable` go to 0 immediately, no `done`. After release, a new `req0` completes normally.
